// File: rtl/count_display_pkg.sv
// rtl/count_display_pkg.sv - shared constants, hex glyph table and scan FSM states
package count_display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; b and d are lowercase glyphs
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational 4-bit to active-low 7-segment decoder
module hex_to_7seg
  import count_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/count_display_scan.sv
// rtl/count_display_scan.sv - multiplexed 7-segment scan of a counter value, frame-snapshotted
// Optional macro LEAD_ZERO_BLANK_EN blanks digits above the most-significant nonzero nibble.
module count_display_scan
  import count_display_pkg::*;
#(
  parameter int Nbits       = 4,
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Nbits-1:0] counter,
  output logic [6:0]       seg,
  output logic [NDIG-1:0]  an,
  output logic             frame
);

  localparam int SW  = $clog2(REFRESH_DIV);
  localparam int DW  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SNW = 4 * NDIG;

  logic [SW-1:0]  slot_cnt;
  logic [DW-1:0]  dig;
  logic [SNW-1:0] snap;
  scan_state_t    state_q, state_d;
  logic           slot_wrap, dig_last;
  logic [3:0]     nib;
  logic [6:0]     dec_seg;
  logic           blank_dig;

  assign slot_wrap = (slot_cnt == SW'(REFRESH_DIV - 1));
  assign dig_last  = (dig == DW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      dig      <= '0;
      snap     <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      dig      <= dig_last ? '0 : dig + DW'(1);
      if (dig_last)
        snap <= SNW'(counter);
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= BLANK;
    else     state_q <= state_d;
  end

  // DRIVE begins on the cycle slot_cnt becomes BLANK_CYC
  always_comb begin
    state_d = state_q;
    if (slot_wrap)
      state_d = BLANK;
    else if (slot_cnt == SW'(BLANK_CYC - 1))
      state_d = DRIVE;
  end

  always_comb begin
    nib = '0;
    for (int i = 0; i < NDIG; i++)
      if (dig == DW'(i)) nib = snap[4*i +: 4];
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic [DW-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 0; i < NDIG; i++)
      if (snap[4*i +: 4] != 4'h0) msd = DW'(i);
  end
  assign blank_dig = (dig > msd);
`else
  assign blank_dig = 1'b0;
`endif

  hex_to_7seg u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an    <= '1;
      seg   <= SEG_OFF;
      frame <= 1'b0;
    end else begin
      frame <= slot_wrap && dig_last;
      if (state_q == DRIVE) begin
        an  <= ~(NDIG'(1) << dig);
        seg <= blank_dig ? SEG_OFF : dec_seg;
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_count_display_scan.sv
// tb/tb_count_display_scan.sv - randomized bench for count_display_scan against a frame-level model
module tb_count_display_scan;

  localparam int R  = 4;
  localparam int BC = 1;
  localparam int N  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] counter = 4'h0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame;

  int vec = 0;
  int miss = 0;

  count_display_scan #(.Nbits(4), .NDIG(N), .REFRESH_DIV(R), .BLANK_CYC(BC)) dut (
    .clk     (clk),
    .rst     (rst),
    .counter (counter),
    .seg     (seg),
    .an      (an),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: glyph = 7'h40;  1: glyph = 7'h79;  2: glyph = 7'h24;  3: glyph = 7'h30;
      4: glyph = 7'h19;  5: glyph = 7'h12;  6: glyph = 7'h02;  7: glyph = 7'h78;
      8: glyph = 7'h00;  9: glyph = 7'h10; 10: glyph = 7'h08; 11: glyph = 7'h03;
      12: glyph = 7'h46; 13: glyph = 7'h21; 14: glyph = 7'h06; default: glyph = 7'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k is the number of cycles since reset; slot/digit/phase follow by division
  int         k = 0;
  int         m_snap = 0;
  bit         m_valid = 0;
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_frame = 1'b0;

  always @(posedge clk) begin
    int slot, d, nibv, msd;
    if (rst) begin
      k = 0; m_snap = 0; m_valid = 1;
      e_an = 4'hF; e_seg = 7'h7F; e_frame = 1'b0;
    end else if (m_valid) begin
      slot = k % R;
      d    = (k / R) % N;
      if (slot >= BC) begin
        e_an = 4'(15 - (1 << d));
        nibv = (m_snap >> (4 * d)) & 15;
        e_seg = glyph(nibv);
`ifdef LEAD_ZERO_BLANK_EN
        msd = 0;
        for (int i = 0; i < N; i++) if (((m_snap >> (4 * i)) & 15) != 0) msd = i;
        if (d > msd) e_seg = 7'h7F;
`endif
      end else begin
        e_an = 4'hF; e_seg = 7'h7F;
      end
      k++;
      e_frame = (k % (R * N) == 0);
      if (e_frame) m_snap = int'(counter);
    end
  end

  int  gap = 0;
  bit  gap_seen = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      vec++;
      if (an !== e_an || seg !== e_seg || frame !== e_frame) begin
        miss++;
        $display("FAIL model: an=%b seg=%h frame=%b expected an=%b seg=%h frame=%b at %0t",
                 an, seg, frame, e_an, e_seg, e_frame, $time);
      end
      vec++;
      if ($countones(~an) > 1) begin
        miss++;
        $display("FAIL onehot: an=%b has more than one low bit at %0t", an, $time);
      end
      if (rst) gap_seen = 0;
      gap++;
      if (frame === 1'b1) begin
        if (gap_seen) chk("frame_period", gap, R * N);
        gap = 0;
        gap_seen = 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame();
    bit ok = 0;
    for (int i = 0; i < 4 * R * N && !ok; i++) begin
      @(negedge clk);
      if (frame === 1'b1) ok = 1;
    end
    chk("frame_found", int'(ok), 1);
  endtask

  initial begin
    rst = 1'b1; counter = 4'h0;
    step(3);
    chk("rst_an", int'(an), 4'hF);
    chk("rst_seg", int'(seg), 7'h7F);
    chk("rst_frame", int'(frame), 0);
    rst = 1'b0;
    step(2);
    chk("first_drive_an", int'(an), 4'b1110);

    counter = 4'hA;
    wait_frame();
    step(2);
    chk("a_an", int'(an), 4'b1110);
    chk("a_seg", int'(seg), 7'h08);
    step(4);
    chk("d1_an", int'(an), 4'b1101);
`ifdef LEAD_ZERO_BLANK_EN
    chk("d1_seg", int'(seg), 7'h7F);
`else
    chk("d1_seg", int'(seg), 7'h40);
`endif

    counter = 4'h3;
    wait_frame();
    counter = 4'h2;
    step(2);
    chk("hold3_seg", int'(seg), 7'h30);
    wait_frame();
    step(2);
    chk("show2_seg", int'(seg), 7'h24);

`ifdef LEAD_ZERO_BLANK_EN
    counter = 4'h0;
    wait_frame();
    step(2);
    chk("lz_d0_seg", int'(seg), 7'h40);
    step(4);
    chk("lz_d1_an", int'(an), 4'b1101);
    chk("lz_d1_seg", int'(seg), 7'h7F);
`endif

    wait_frame();
    step(10);
    chk("d2_drive_an", int'(an), 4'b1011);
    rst = 1'b1;
    step(1);
    chk("midrst_an", int'(an), 4'hF);
    chk("midrst_seg", int'(seg), 7'h7F);
    rst = 1'b0;
    step(2);
    chk("resume_an", int'(an), 4'b1110);

    for (int i = 0; i < 1500; i++) begin
      if (i < 500 || $urandom_range(0, 7) == 0) counter = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
